// File: rtl/moving_average_ctrl.sv
// Moving-average datapath controller.
//
// Accepts a window-length configuration and runs a reconfiguration sequence of
// CLEAR, FILL and SETTLE before it enters RUN. CLEAR asserts the datapath clear
// for CLEAR_LEN cycles. FILL counts ma_window accepted samples. SETTLE waits
// PIPE_LATENCY cycles for the datapath pipeline to drain. While RUN is active,
// downstream sees the datapath's valid signal through a register.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_window/cfg_valid  configuration request (must be a power of two)
//   cfg_ready             configuration can be accepted (IDLE or RUN)
//   cfg_error             one-cycle pulse after a rejected configuration
//   in_valid              upstream sample valid
//   ma_window             window driven to the datapath
//   ma_enable             sample valid forwarded to the datapath (combinational)
//   ma_clear              datapath clear request
//   ma_valid              datapath output valid
//   out_valid             qualified average valid to downstream
//   busy                  reconfiguration in progress
module moving_average_ctrl #(
    parameter int unsigned WINDOW_SIZE  = 6,
    parameter int unsigned CLEAR_LEN    = 4,
    parameter int unsigned PIPE_LATENCY = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WINDOW_SIZE:0] cfg_window,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 cfg_error,
    input  logic                 in_valid,
    output logic [WINDOW_SIZE:0] ma_window,
    output logic                 ma_enable,
    output logic                 ma_clear,
    input  logic                 ma_valid,
    output logic                 out_valid,
    output logic                 busy
);

    localparam logic [3:0] ClearLast  = 4'(CLEAR_LEN - 1);
    localparam logic [3:0] SettleLast = 4'(PIPE_LATENCY - 1);
    localparam logic [WINDOW_SIZE:0] One = {{WINDOW_SIZE{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFill,
        StSettle,
        StRun
    } state_e;

    state_e               state_q;
    logic [3:0]           phase_cnt_q;  // shared by CLEAR and SETTLE
    logic [WINDOW_SIZE:0] fill_cnt_q;
    logic [WINDOW_SIZE:0] fill_cnt_inc;
    logic                 handshake;
    logic                 cfg_legal;

    // A legal window has exactly one bit set.
    assign cfg_legal    = (cfg_window != '0) && ((cfg_window & (cfg_window - One)) == '0);
    // cfg_ready is high only in IDLE and RUN, so it also qualifies the handshake.
    assign handshake    = cfg_valid && cfg_ready;
    assign fill_cnt_inc = fill_cnt_q + One;

    assign ma_enable = in_valid &&
                       ((state_q == StFill) || (state_q == StSettle) || (state_q == StRun));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            phase_cnt_q <= '0;
            fill_cnt_q  <= '0;
            cfg_ready   <= 1'b1;
            cfg_error   <= 1'b0;
            ma_window   <= One;
            ma_clear    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cfg_error <= 1'b0;
            out_valid <= 1'b0;
            case (state_q)
                StIdle, StRun: begin
                    if (handshake && cfg_legal) begin
                        // A configuration wins over RUN, so out_valid drops on the next cycle.
                        state_q     <= StClear;
                        ma_window   <= cfg_window;
                        ma_clear    <= 1'b1;
                        busy        <= 1'b1;
                        cfg_ready   <= 1'b0;
                        phase_cnt_q <= '0;
                        fill_cnt_q  <= '0;
                    end else begin
                        cfg_error <= handshake;
                        if (state_q == StRun) begin
                            out_valid <= ma_valid;
                        end
                    end
                end
                StClear: begin
                    if (phase_cnt_q == ClearLast) begin
                        state_q  <= StFill;
                        ma_clear <= 1'b0;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 4'd1;
                    end
                end
                StFill: begin
                    if (in_valid) begin
                        fill_cnt_q <= fill_cnt_inc;
                        if (fill_cnt_inc == ma_window) begin
                            state_q     <= StSettle;
                            phase_cnt_q <= '0;
                        end
                    end
                end
                StSettle: begin
                    if (phase_cnt_q == SettleLast) begin
                        state_q   <= StRun;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    ma_clear  <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moving_average_ctrl.sv
module tb_moving_average_ctrl;

    localparam int unsigned WS = 6;
    localparam int unsigned CL = 4;
    localparam int unsigned PL = 5;
    localparam int unsigned W  = WS + 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] cfg_window = '0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic         cfg_error;
    logic         in_valid = 1'b0;
    logic [W-1:0] ma_window;
    logic         ma_enable;
    logic         ma_clear;
    logic         ma_valid = 1'b0;
    logic         out_valid;
    logic         busy;

    moving_average_ctrl #(
        .WINDOW_SIZE (WS),
        .CLEAR_LEN   (CL),
        .PIPE_LATENCY(PL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_window(cfg_window),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_error (cfg_error),
        .in_valid  (in_valid),
        .ma_window (ma_window),
        .ma_enable (ma_enable),
        .ma_clear  (ma_clear),
        .ma_valid  (ma_valid),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining work in each phase of a reconfiguration.
    bit m_cfgd;
    int m_clear_left;
    int m_fill_left;
    int m_settle_left;
    int m_window;
    bit m_err;
    bit m_ov;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (m_clear_left > 0) || (m_fill_left > 0) || (m_settle_left > 0);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    task automatic model_reset();
        m_cfgd = 0; m_clear_left = 0; m_fill_left = 0; m_settle_left = 0;
        m_window = 1; m_err = 0; m_ov = 0;
    endtask

    task automatic model_edge(input bit cv, input logic [W-1:0] cw, input bit iv, input bit mv);
        bit in_run = m_cfgd && !m_busy();
        bit hs     = cv && !m_busy();
        bit legal  = hs && is_pow2(int'(cw));
        m_ov  = in_run && !legal && mv;
        m_err = hs && !legal;
        if (legal) begin
            m_cfgd = 1; m_window = int'(cw);
            m_clear_left = CL; m_fill_left = int'(cw); m_settle_left = PL;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_fill_left > 0) begin
            if (iv) m_fill_left--;
        end else if (m_settle_left > 0) begin
            m_settle_left--;
        end
    endtask

    task automatic check_regs();
        chk("cfg_ready", cfg_ready, !m_busy());
        chk("cfg_error", cfg_error, m_err);
        chk("ma_window", ma_window, m_window);
        chk("ma_clear", ma_clear, m_clear_left > 0);
        chk("busy", busy, m_busy());
        chk("out_valid", out_valid, m_ov);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit cv, input logic [W-1:0] cw, input bit iv, input bit mv);
        cfg_valid = cv; cfg_window = cw; in_valid = iv; ma_valid = mv;
        #1;
        chk("ma_enable", ma_enable, iv && m_cfgd && (m_clear_left == 0));
        @(posedge clk);
        model_edge(cv, cw, iv, mv);
        @(negedge clk);
        check_regs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_window = '0; in_valid = 1'b1; ma_valid = 1'b1;
        #1;
        model_reset();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_cfg_error", cfg_error, 0);
        chk("rst_ma_window", ma_window, 1);
        chk("rst_ma_clear", ma_clear, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ma_enable", ma_enable, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit           cv;
        logic [W-1:0] cw;
        bit           iv;
        bit           mv;
        bit           e_en;
        bit           e_rdy;
        bit           e_err;
        logic [W-1:0] e_win;
        bit           e_clr;
        bit           e_busy;
        bit           e_ov;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        int nclr;

        //           cv  cw     iv  mv   en  rdy err win    clr bsy ov
        vecs[0] = '{1'b1, 7'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 7'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 7'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b1, 1'b0};

        model_reset();
        do_reset();

        // Illegal configurations in IDLE, then a legal one and a request ignored in CLEAR.
        for (int i = 0; i < 7; i++) begin
            cfg_valid = vecs[i].cv; cfg_window = vecs[i].cw;
            in_valid = vecs[i].iv; ma_valid = vecs[i].mv;
            #1;
            chk($sformatf("vec%0d_ma_enable", i), ma_enable, vecs[i].e_en);
            @(posedge clk);
            model_edge(vecs[i].cv, vecs[i].cw, vecs[i].iv, vecs[i].mv);
            @(negedge clk);
            chk($sformatf("vec%0d_cfg_ready", i), cfg_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_cfg_error", i), cfg_error, vecs[i].e_err);
            chk($sformatf("vec%0d_ma_window", i), ma_window, vecs[i].e_win);
            chk($sformatf("vec%0d_ma_clear", i), ma_clear, vecs[i].e_clr);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Window 8, constant in_valid: RUN 17 cycles after the handshake edge.
        do_reset();
        step(1'b1, 7'd8, 1'b1, 1'b0);
        nclr = ma_clear; n = 0;
        while (busy && n < 100) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
            nclr += ma_clear;
        end
        chk("w8_run_latency", n, CL + 8 + PL);
        chk("w8_clear_cycles", nclr, CL);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("w8_out_valid_follow", out_valid, 1);

        // Reconfigure to 64 in RUN while a sample arrives.
        step(1'b1, 7'd64, 1'b1, 1'b1);
        chk("w64_out_valid_drop", out_valid, 0);
        chk("w64_clear", ma_clear, 1);
        chk("w64_window", ma_window, 64);
        n = 0;
        while (busy && n < 200) begin
            step(1'b0, '0, 1'b1, 1'b1);
            n++;
        end
        chk("w64_run_latency", n, CL + 64 + PL);

        // Window 4 with alternating in_valid: FILL spans 7 cycles.
        do_reset();
        step(1'b1, 7'd4, 1'b0, 1'b0);
        n = 0;
        for (int k = 1; k < 100 && busy; k++) begin
            step(1'b0, '0, (k % 2) == 1, 1'b0);
            n++;
        end
        chk("w4_run_latency", n, CL + 7 + PL);

        // Window 1: FILL exits after one valid; request held in SETTLE waits for RUN.
        step(1'b1, 7'd1, 1'b0, 1'b0);
        for (int k = 0; k < CL; k++) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("w1_busy_after_fill", busy, 1);
        for (int k = 0; k < PL - 1; k++) step(1'b1, 7'd2, 1'b0, 1'b0);
        chk("w1_held_window", ma_window, 1);
        chk("w1_held_clear", ma_clear, 0);
        step(1'b1, 7'd2, 1'b0, 1'b0);
        chk("w1_run_ready", cfg_ready, 1);
        step(1'b1, 7'd2, 1'b0, 1'b0);
        chk("w1_accept_window", ma_window, 2);
        chk("w1_accept_clear", ma_clear, 1);

        // Reset mid-FILL (window 16, 9 samples counted).
        do_reset();
        step(1'b1, 7'd16, 1'b1, 1'b0);
        for (int k = 0; k < CL + 9; k++) step(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 7'd16, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic [W-1:0] cw;
            if ($urandom_range(0, 1) == 0) cw = W'(1 << $urandom_range(0, WS));
            else cw = W'($urandom_range(0, (1 << W) - 1));
            step($urandom_range(0, 7) == 0, cw, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
